// File: rtl/random_victim_sel_if.sv
// random_victim_sel_if: request/victim handshake between a miss controller and the victim selector.
interface random_victim_sel_if #(parameter int WAYS = 4);
    localparam int IDX_W = $clog2(WAYS);
    logic             req;
    logic [WAYS-1:0]  valid_mask;
    logic [WAYS-1:0]  lock_mask;
    logic             victim_valid;
    logic [IDX_W-1:0] victim_way;
    logic             victim_none;
    logic             victim_ack;
    modport master (output req, valid_mask, lock_mask, victim_ack,
                    input  victim_valid, victim_way, victim_none);
    modport slave  (input  req, valid_mask, lock_mask, victim_ack,
                    output victim_valid, victim_way, victim_none);
endinterface

// File: rtl/random_victim_sel.sv
// random_victim_sel: picks a cache/TLB victim way, free ways first, else an LFSR-seeded scan of unlocked ways.
// Optional macro RANDOM_VICTIM_NO_REPEAT_EN avoids picking the previous random victim twice in a row.
module random_victim_sel #(
    parameter int WAYS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] lfsr,
    output logic        lfsr_update,
    random_victim_sel_if.slave bus
);
    localparam int IDX_W = $clog2(WAYS);
    typedef enum logic [1:0] {IDLE, SELECT, HOLD} state_t;
    state_t           state, state_nx;
    logic [WAYS-1:0]  vm_q, lm_q, free, cand;
    logic [IDX_W-1:0] way_q, way_nx, scan;
    logic             none_q, rnd, cap;
    logic             unused_lfsr;
`ifdef RANDOM_VICTIM_NO_REPEAT_EN
    logic [IDX_W-1:0] last_way;
`endif

    // First set bit of m starting at index s, wrapping modulo WAYS.
    function automatic logic [IDX_W-1:0] first_set(input logic [WAYS-1:0] m, input logic [IDX_W-1:0] s);
        logic [IDX_W-1:0] r, idx;
        r = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            idx = s + IDX_W'(i);
            if (m[idx]) r = idx;
        end
        return r;
    endfunction

    assign unused_lfsr = ^lfsr[63:IDX_W];

    always_comb begin
        free = ~vm_q & ~lm_q;
        cand = ~lm_q;
        rnd  = (free == '0) && (cand != '0);
        scan = first_set(cand, lfsr[IDX_W-1:0]);
`ifdef RANDOM_VICTIM_NO_REPEAT_EN
        scan = (scan == last_way && (cand & (cand - WAYS'(1))) != '0)
             ? first_set(cand, last_way + IDX_W'(1)) : scan;
`endif
        way_nx   = (free != '0) ? first_set(free, '0) : rnd ? scan : '0;
        cap      = bus.req && (state == IDLE || (state == HOLD && bus.victim_ack));
        state_nx = (state == IDLE)   ? (bus.req ? SELECT : IDLE)
                 : (state == SELECT) ? HOLD
                 : (state == HOLD)   ? (bus.victim_ack ? (bus.req ? SELECT : IDLE) : HOLD)
                 : IDLE;
        lfsr_update      = (state == SELECT) && rnd && !rst;
        bus.victim_valid = (state == HOLD);
        bus.victim_way   = way_q;
        bus.victim_none  = none_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            vm_q   <= '0;
            lm_q   <= '0;
            way_q  <= '0;
            none_q <= 1'b0;
`ifdef RANDOM_VICTIM_NO_REPEAT_EN
            last_way <= '0;
`endif
        end else begin
            state <= state_nx;
            if (cap) begin
                vm_q   <= bus.valid_mask;
                lm_q   <= bus.lock_mask;
                none_q <= 1'b0;
            end
            if (state == SELECT) begin
                way_q  <= way_nx;
                none_q <= (cand == '0);
`ifdef RANDOM_VICTIM_NO_REPEAT_EN
                if (rnd) last_way <= way_nx;
`endif
            end
        end
    end
endmodule

// File: tb/tb_random_victim_sel.sv
// tb_random_victim_sel: directed and randomized checks of random_victim_sel against a behavioural model.
module tb_random_victim_sel;
    logic        clk = 0;
    logic        rst = 1;
    logic [63:0] lfsr = '0;
    logic        lfsr_update;
    int          checks = 0, errors = 0;
    int          exp_upd = 0, upd_seen = 0, consec = 0;
    bit          prev_upd = 0, in_hold = 0;
    int          last_w = 0;

    random_victim_sel_if #(.WAYS(4)) bus();
    random_victim_sel #(.WAYS(4)) dut (.clk(clk), .rst(rst), .lfsr(lfsr), .lfsr_update(lfsr_update), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (lfsr_update) upd_seen++;
        if (lfsr_update && prev_upd) consec++;
        prev_upd = lfsr_update;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Free ways by lowest index, otherwise first unlocked way walking upward from start, wrapping.
    function automatic void model(input logic [3:0] vm, input logic [3:0] lm, input int start,
                                  output int way, output bit none, output bit rnd);
        int fi = -1;
        for (int i = 0; i < 4; i++) if (!vm[i] && !lm[i] && fi < 0) fi = i;
        none = (lm == 4'hF) && fi < 0;
        rnd  = 0;
        way  = 0;
        if (fi >= 0) way = fi;
        else if (!none) begin
            rnd = 1;
            for (int k = 0; k < 4; k++) if (!lm[(start + k) % 4]) begin way = (start + k) % 4; break; end
`ifdef RANDOM_VICTIM_NO_REPEAT_EN
            if (way == last_w && $countones(~lm) >= 2)
                for (int k = 1; k < 4; k++) if (!lm[(last_w + k) % 4]) begin way = (last_w + k) % 4; break; end
`endif
        end
    endfunction

    task automatic txn(input logic [3:0] vm, input logic [3:0] lm, input logic [63:0] lv, input bit b2b);
        int  way;
        bit  none, rnd;
        bus.req = 1; bus.valid_mask = vm; bus.lock_mask = lm; bus.victim_ack = b2b; lfsr = lv;
        model(vm, lm, int'(lv[1:0]), way, none, rnd);
        if (rnd) begin exp_upd++; last_w = way; end
        @(negedge clk);
        bus.req = 0; bus.victim_ack = 0;
        bus.valid_mask = 4'($urandom()); bus.lock_mask = 4'($urandom());
        check("sel_valid", bus.victim_valid, 0);
        check("sel_upd", lfsr_update, rnd);
        @(negedge clk);
        lfsr = {$urandom(), $urandom()};
        check("hold_valid", bus.victim_valid, 1);
        check("hold_way", bus.victim_way, way);
        check("hold_none", bus.victim_none, none);
        check("hold_upd", lfsr_update, 0);
        in_hold = 1;
    endtask

    task automatic release_hold();
        bus.victim_ack = 1;
        @(negedge clk);
        bus.victim_ack = 0;
        check("idle_valid", bus.victim_valid, 0);
        in_hold = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        last_w = 0;
        in_hold = 0;
    endtask

    initial begin
        logic [3:0] way_before;
        bus.req = 0; bus.valid_mask = '0; bus.lock_mask = '0; bus.victim_ack = 0;
        repeat (3) @(negedge clk);
        check("rst_valid", bus.victim_valid, 0);
        check("rst_way", bus.victim_way, 0);
        check("rst_none", bus.victim_none, 0);
        check("rst_upd", lfsr_update, 0);
        rst = 0;
        txn(4'b1011, 4'h0, {$urandom(), $urandom()}, 0);
        release_hold();
        txn(4'hF, 4'h0, {$urandom(), $urandom() | 32'h3}, 0);
        release_hold();
        txn(4'hF, 4'b1001, {$urandom(), $urandom() | 32'h3}, 0);
        release_hold();
        txn(4'hF, 4'hF, {$urandom(), $urandom()}, 0);
        way_before = 4'(bus.victim_way);
        for (int i = 0; i < 5; i++) begin
            bus.req = 1; bus.valid_mask = 4'($urandom()); bus.lock_mask = 4'($urandom());
            @(negedge clk);
            check("stall_valid", bus.victim_valid, 1);
            check("stall_none", bus.victim_none, 1);
            check("stall_way", bus.victim_way, way_before);
        end
        txn(4'b0111, 4'h0, {$urandom(), $urandom()}, 1);
        release_hold();
        bus.req = 1; bus.valid_mask = 4'hF; bus.lock_mask = 4'h0; lfsr = {$urandom(), $urandom()};
        @(negedge clk);
        bus.req = 0;
        rst = 1;
        #1 check("abort_upd", lfsr_update, 0);
        @(negedge clk);
        rst = 0;
        last_w = 0;
        check("abort_valid", bus.victim_valid, 0);
        @(negedge clk);
        check("abort_idle", bus.victim_valid, 0);
`ifdef RANDOM_VICTIM_NO_REPEAT_EN
        do_reset();
        txn(4'hF, 4'h0, 64'h2, 0);
        check("norep_first", bus.victim_way, 2);
        release_hold();
        txn(4'hF, 4'h0, 64'h2, 0);
        check("norep_second", bus.victim_way, 3);
        release_hold();
`endif
        for (int n = 0; n < 80; n++) begin
            logic [3:0] vm, lm;
            vm = 4'($urandom());
            lm = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom());
            if ($urandom_range(0, 3) == 0) vm = 4'hF;
            if (in_hold && $urandom_range(0, 1) == 1) txn(vm, lm, {$urandom(), $urandom()}, 1);
            else begin
                if (in_hold) release_hold();
                txn(vm, lm, {$urandom(), $urandom()}, 0);
            end
        end
        release_hold();
        @(negedge clk);
        check("upd_count", upd_seen, exp_upd);
        check("upd_consec", consec, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
